// File: rtl/dct_idct_frame_sequencer.sv
// dct_idct_frame_sequencer
// Pushes one frame of 8x8 blocks through an external dct -> idct pair.
// Source pixels are metered into the dct while it reports reading, dct
// coefficients are sign-extended into the idct, and both the coefficient and
// reconstructed-pixel streams are captured 64 samples per output window.
// The frame ends when every block has come back out of the idct, or when the
// drain phase runs out of time.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   go, abort               frame start (IDLE only), return to IDLE (top priority)
//   src_valid/src_data      source pixel stream, src_ready = accepted this cycle
//   dct_start, dct_din      dct control and registered pixel
//   dct_reading/done/dout   dct status and output
//   idct_din                sign-extended dct coefficient (combinational)
//   idct_racc, idct_rapx    idct reset and approximate-mode select
//   idct_done, idct_dout    idct output window and data
//   coef_valid/coef_data    captured coefficients (dct_dout[31:18])
//   pix_valid/pix_data      captured pixels (idct_dout[31:10])
//   busy, frame_done        activity flag, one-cycle end-of-frame pulse
//   timeout                 sticky drain-timeout flag, cleared by go
//   cycle_cnt               saturating cycles since go
//
// state | meaning
// IDLE  | waiting for go; idct held in reset
// LOAD  | feeding NUM_BLOCKS*64 source pixels into the dct
// DRAIN | waiting for the last idct block or the drain timeout
// DONE  | single cycle, frame_done asserted

module dct_idct_frame_sequencer #(
  parameter int   BitWidth      = 31,
  parameter int   NUM_BLOCKS    = 1024,
  parameter int   DRAIN_TIMEOUT = 16384,
  parameter int   APX_LO        = 500000,
  parameter int   APX_HI        = 1000000,
  parameter logic APX_DEFAULT   = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              go,
  input  logic              abort,
  input  logic              src_valid,
  input  logic [BitWidth:0] src_data,
  output logic              src_ready,
  output logic              dct_start,
  output logic [BitWidth:0] dct_din,
  input  logic              dct_reading,
  input  logic              dct_done,
  input  logic [BitWidth:0] dct_dout,
  output logic [BitWidth:0] idct_din,
  output logic              idct_racc,
  output logic              idct_rapx,
  input  logic              idct_done,
  input  logic [BitWidth:0] idct_dout,
  output logic              coef_valid,
  output logic [13:0]       coef_data,
  output logic              pix_valid,
  output logic [21:0]       pix_data,
  output logic              busy,
  output logic              frame_done,
  output logic              timeout,
  output logic [31:0]       cycle_cnt
);

  localparam int SAMPLES = NUM_BLOCKS * 64;
  localparam int IN_W    = $clog2(SAMPLES + 1);
  localparam int BLK_W   = $clog2(NUM_BLOCKS + 1);
  localparam int DRN_W   = $clog2(DRAIN_TIMEOUT + 1);

  localparam logic [IN_W-1:0]  IN_LAST  = IN_W'(SAMPLES - 1);
  localparam logic [BLK_W-1:0] BLK_ALL  = BLK_W'(NUM_BLOCKS);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_TIMEOUT - 1);
  localparam logic [31:0]      APX_LO_C = 32'(APX_LO);
  localparam logic [31:0]      APX_HI_C = 32'(APX_HI);
  localparam logic [6:0]       CAP_FULL = 7'd64;
  localparam logic [6:0]       CAP_LAST = 7'd63;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t           state;
  logic [IN_W-1:0]  in_cnt;
  logic [BLK_W-1:0] blk_cnt;
  logic [BLK_W-1:0] blk_cnt_nxt;
  logic [DRN_W-1:0] drain_cnt;
  logic [6:0]       coef_cnt;
  logic [6:0]       pix_cnt;
  logic             active;
  logic             blk_full;
  logic             apx_win;
  logic             unused_low;

  assign active    = (state != IDLE);
  assign busy      = active;
  assign src_ready = (state == LOAD) && dct_reading;
  assign idct_din  = {{(BitWidth - 13){dct_dout[BitWidth]}}, dct_dout[BitWidth -: 14]};
  assign unused_low = ^{dct_dout[BitWidth-14:0], idct_dout[BitWidth-22:0]};

  // Block count including a block that completes on this very edge, so a
  // final block landing on the timeout cycle still counts as completion.
  always_comb begin
    blk_cnt_nxt = blk_cnt;
    if (active && idct_done && (pix_cnt == CAP_LAST) && (blk_cnt != BLK_ALL))
      blk_cnt_nxt = blk_cnt + 1'b1;
  end

  assign blk_full = (blk_cnt_nxt == BLK_ALL);
  assign apx_win  = (cycle_cnt > APX_LO_C) && (cycle_cnt < APX_HI_C);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      dct_start  <= 1'b0;
      dct_din    <= '0;
      idct_racc  <= 1'b1;
      idct_rapx  <= APX_DEFAULT;
      coef_valid <= 1'b0;
      coef_data  <= '0;
      pix_valid  <= 1'b0;
      pix_data   <= '0;
      frame_done <= 1'b0;
      timeout    <= 1'b0;
      cycle_cnt  <= '0;
      in_cnt     <= '0;
      blk_cnt    <= '0;
      drain_cnt  <= '0;
      coef_cnt   <= '0;
      pix_cnt    <= '0;
    end else if (abort) begin
      state      <= IDLE;
      dct_start  <= 1'b0;
      idct_racc  <= 1'b1;
      idct_rapx  <= APX_DEFAULT;
      coef_valid <= 1'b0;
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
      cycle_cnt  <= '0;
      in_cnt     <= '0;
      blk_cnt    <= '0;
      drain_cnt  <= '0;
      coef_cnt   <= '0;
      pix_cnt    <= '0;
    end else begin
      if (active) begin
        if (dct_done) begin
          if (coef_cnt != CAP_FULL) begin
            coef_valid <= 1'b1;
            coef_data  <= dct_dout[BitWidth -: 14];
            coef_cnt   <= coef_cnt + 1'b1;
          end else begin
            coef_valid <= 1'b0;
          end
        end else begin
          coef_valid <= 1'b0;
          coef_cnt   <= '0;
        end

        if (idct_done) begin
          if (pix_cnt != CAP_FULL) begin
            pix_valid <= 1'b1;
            pix_data  <= idct_dout[BitWidth -: 22];
            pix_cnt   <= pix_cnt + 1'b1;
          end else begin
            pix_valid <= 1'b0;
          end
        end else begin
          pix_valid <= 1'b0;
          pix_cnt   <= '0;
        end

        if (cycle_cnt != '1)
          cycle_cnt <= cycle_cnt + 1'b1;
        idct_rapx <= apx_win ? 1'b1 : APX_DEFAULT;
      end else begin
        coef_valid <= 1'b0;
        coef_cnt   <= '0;
        pix_valid  <= 1'b0;
        pix_cnt    <= '0;
      end

      blk_cnt    <= blk_cnt_nxt;
      frame_done <= 1'b0;

      case (state)
        IDLE: begin
          idct_racc <= 1'b1;
          idct_rapx <= APX_DEFAULT;
          dct_start <= 1'b0;
          if (go) begin
            state     <= LOAD;
            idct_racc <= 1'b0;
            dct_start <= 1'b1;
            in_cnt    <= '0;
            blk_cnt   <= '0;
            drain_cnt <= '0;
            cycle_cnt <= '0;
            timeout   <= 1'b0;
          end
        end
        LOAD: begin
          if (src_valid && dct_reading) begin
            dct_din <= src_data;
            in_cnt  <= in_cnt + 1'b1;
            if (in_cnt == IN_LAST) begin
              state     <= DRAIN;
              drain_cnt <= '0;
            end
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          // once the dct stops reading, start stays low for the rest of the frame
          if (!dct_reading)
            dct_start <= 1'b0;
          if (blk_full) begin
            state      <= DONE;
            frame_done <= 1'b1;
            dct_start  <= 1'b0;
          end else if (drain_cnt == DRN_LAST) begin
            state      <= DONE;
            frame_done <= 1'b1;
            timeout    <= 1'b1;
            dct_start  <= 1'b0;
          end
        end
        DONE: begin
          state     <= IDLE;
          idct_racc <= 1'b1;
          idct_rapx <= APX_DEFAULT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dct_idct_frame_sequencer.sv
module tb_dct_idct_frame_sequencer;

  localparam int   NB = 2;
  localparam int   DT = 16;
  localparam int   LO = 10;
  localparam int   HI = 20;
  localparam logic AD = 1'b0;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        go = 1'b0;
  logic        abort = 1'b0;
  logic        src_valid = 1'b0;
  logic [31:0] src_data = '0;
  logic        src_ready;
  logic        dct_start;
  logic [31:0] dct_din;
  logic        dct_reading = 1'b0;
  logic        dct_done = 1'b0;
  logic [31:0] dct_dout = '0;
  logic [31:0] idct_din;
  logic        idct_racc;
  logic        idct_rapx;
  logic        idct_done = 1'b0;
  logic [31:0] idct_dout = '0;
  logic        coef_valid;
  logic [13:0] coef_data;
  logic        pix_valid;
  logic [21:0] pix_data;
  logic        busy;
  logic        frame_done;
  logic        timeout;
  logic [31:0] cycle_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // values the outputs are expected to hold between updates
  logic [31:0] din_model = '0;
  logic [13:0] coef_model = '0;
  logic [21:0] pix_model = '0;

  dct_idct_frame_sequencer #(
    .BitWidth(31), .NUM_BLOCKS(NB), .DRAIN_TIMEOUT(DT),
    .APX_LO(LO), .APX_HI(HI), .APX_DEFAULT(AD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .go(go), .abort(abort),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .dct_start(dct_start), .dct_din(dct_din), .dct_reading(dct_reading),
    .dct_done(dct_done), .dct_dout(dct_dout), .idct_din(idct_din),
    .idct_racc(idct_racc), .idct_rapx(idct_rapx), .idct_done(idct_done),
    .idct_dout(idct_dout), .coef_valid(coef_valid), .coef_data(coef_data),
    .pix_valid(pix_valid), .pix_data(pix_data), .busy(busy),
    .frame_done(frame_done), .timeout(timeout), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({dct_start, src_ready, idct_racc, idct_rapx, coef_valid, pix_valid, busy, frame_done, timeout}
        !== {1'b0, 1'b0, 1'b1, AD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_flags: got %b", {dct_start, src_ready, idct_racc, idct_rapx, coef_valid,
               pix_valid, busy, frame_done, timeout});
    end
    n_cmp++;
    if ({dct_din, coef_data, pix_data, cycle_cnt} !== 100'd0) begin
      n_bad++;
      $display("FAIL reset_data: din=%h coef=%h pix=%h cyc=%0d want all zero", dct_din, coef_data, pix_data, cycle_cnt);
    end
    din_model = '0; coef_model = '0; pix_model = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    tick();
  endtask

  // Load a full frame then let the drain phase time out (no idct output).
  task automatic test_load_timeout(input bit rand_hs);
    int acc, rdy, guard, r;
    logic v, rd;
    logic [31:0] d;
    acc = 0; rdy = 0; guard = 0;
    go = 1'b1; tick(); go = 1'b0;
    n_cmp++;
    if ({busy, idct_racc, dct_start, timeout, frame_done} !== 5'b10100) begin
      n_bad++;
      $display("FAIL go_entry: got %b want 10100", {busy, idct_racc, dct_start, timeout, frame_done});
    end
    while (acc < NB * 64 && guard < 4000) begin
      guard++;
      v  = rand_hs ? ($urandom_range(0, 3) != 0) : 1'b1;
      rd = rand_hs ? ($urandom_range(0, 3) != 0) : 1'b1;
      d  = $urandom;
      src_valid = v; dct_reading = rd; src_data = d;
      #1;
      n_cmp++;
      if (src_ready !== rd) begin
        n_bad++;
        $display("FAIL load_ready: got %b want %b (acc=%0d)", src_ready, rd, acc);
      end
      if (src_ready) rdy++;
      tick();
      if (v && rd) begin
        acc++;
        din_model = d;
      end
      n_cmp++;
      if (dct_din !== din_model) begin
        n_bad++;
        $display("FAIL load_din: got %h want %h", dct_din, din_model);
      end
    end
    n_cmp++;
    if (acc != NB * 64) begin
      n_bad++;
      $display("FAIL load_bound: accepted %0d want %0d", acc, NB * 64);
    end
    if (!rand_hs) begin
      n_cmp++;
      if (rdy != NB * 64) begin
        n_bad++;
        $display("FAIL load_ready_cycles: got %0d want %0d", rdy, NB * 64);
      end
    end
    r = $urandom_range(0, 8);
    for (int k = 1; k <= 18; k++) begin
      src_valid = 1'b1; src_data = $urandom; dct_reading = (k <= r);
      #1;
      n_cmp++;
      if (src_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL drain_ready: got %b want 0 (k=%0d)", src_ready, k);
      end
      tick();
      n_cmp++;
      if ({frame_done, busy, timeout, dct_start, idct_racc} !== {k == 16, k <= 16, k >= 16, k <= r, k > 16}) begin
        n_bad++;
        $display("FAIL drain_flags k=%0d: got %b want %b", k, {frame_done, busy, timeout, dct_start, idct_racc},
                 {k == 16, k <= 16, k >= 16, k <= r, k > 16});
      end
      n_cmp++;
      if (dct_din !== din_model) begin
        n_bad++;
        $display("FAIL drain_din: got %h want %h", dct_din, din_model);
      end
    end
    src_valid = 1'b0; dct_reading = 1'b0;
  endtask

  // Two dct output windows while the frame is held in LOAD.
  task automatic test_coef();
    int len, pulses;
    logic dn, ev;
    logic [31:0] d, exp_sx;
    logic signed [31:0] sd;
    go = 1'b1; src_valid = 1'b0; dct_reading = 1'b1; tick(); go = 1'b0;
    for (int w = 0; w < 2; w++) begin
      len = (w == 0) ? 70 : $urandom_range(50, 80);
      pulses = 0;
      for (int n = 1; n <= len + 2; n++) begin
        dn = (n <= len);
        d = (w == 0) ? 32'hFFFC_0000 : $urandom;
        dct_done = dn; dct_dout = d;
        sd = d;
        exp_sx = sd >>> 18;
        #1;
        n_cmp++;
        if (idct_din !== exp_sx) begin
          n_bad++;
          $display("FAIL idct_din: got %h want %h", idct_din, exp_sx);
        end
        tick();
        ev = dn && (n <= 64);
        if (ev) coef_model = d[31:18];
        n_cmp++;
        if ({coef_valid, coef_data} !== {ev, coef_model}) begin
          n_bad++;
          $display("FAIL coef w=%0d n=%0d: got %b/%h want %b/%h", w, n, coef_valid, coef_data, ev, coef_model);
        end
        if (coef_valid) pulses++;
      end
      n_cmp++;
      if (pulses != ((len < 64) ? len : 64)) begin
        n_bad++;
        $display("FAIL coef_pulses w=%0d: got %0d want %0d", w, pulses, (len < 64) ? len : 64);
      end
    end
    dct_done = 1'b0;
    abort = 1'b1; tick(); abort = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL coef_abort_busy: got %b want 0", busy);
    end
  endtask

  // Full frame with two idct windows; completion vs timeout decided by when
  // the 64th pixel of the second window lands relative to the drain budget.
  task automatic test_blocks(input int s1, input int e1, input int g, input int e2);
    int t_blk, t_done, w2s, run, drain_at;
    bit to;
    logic dn, ev;
    logic [31:0] dout, sdat;
    drain_at = NB * 64;
    w2s   = s1 + 64 + e1 + g + 1;
    t_blk = w2s + 63;
    to    = (t_blk > drain_at + DT);
    t_done = to ? drain_at + DT : ((t_blk < drain_at + 1) ? drain_at + 1 : t_blk);
    run = 0;
    go = 1'b1; src_valid = 1'b1; dct_reading = 1'b1; dct_done = 1'b0; tick(); go = 1'b0;
    for (int e = 1; e <= t_done + 3; e++) begin
      dn = ((e >= s1 + 1) && (e <= s1 + 64 + e1)) ||
           ((e >= w2s) && (e < w2s + 64 + e2) && (e <= t_done + 1));
      dout = $urandom; sdat = $urandom;
      idct_done = dn; idct_dout = dout; src_data = sdat;
      tick();
      if (e <= drain_at) din_model = sdat;
      run = dn ? run + 1 : 0;
      ev = dn && (run <= 64);
      if (ev) pix_model = dout[31:10];
      n_cmp++;
      if ({pix_valid, pix_data} !== {ev, pix_model}) begin
        n_bad++;
        $display("FAIL pix e=%0d: got %b/%h want %b/%h", e, pix_valid, pix_data, ev, pix_model);
      end
      n_cmp++;
      if ({frame_done, busy, timeout} !== {e == t_done, e <= t_done, (e >= t_done) && to}) begin
        n_bad++;
        $display("FAIL blk_flags e=%0d t_blk=%0d: got %b want %b", e, t_blk, {frame_done, busy, timeout},
                 {e == t_done, e <= t_done, (e >= t_done) && to});
      end
    end
    idct_done = 1'b0; src_valid = 1'b0;
  endtask

  task automatic test_rapx();
    logic exp_r;
    go = 1'b1; src_valid = 1'b0; dct_reading = 1'b0; tick(); go = 1'b0;
    n_cmp++;
    if ({idct_rapx, cycle_cnt} !== {AD, 32'd0}) begin
      n_bad++;
      $display("FAIL rapx_start: got %b/%0d want %b/0", idct_rapx, cycle_cnt, AD);
    end
    for (int k = 1; k <= 30; k++) begin
      tick();
      exp_r = ((k - 1) > LO && (k - 1) < HI) ? 1'b1 : AD;
      n_cmp++;
      if ({idct_rapx, cycle_cnt} !== {exp_r, 32'(k)}) begin
        n_bad++;
        $display("FAIL rapx k=%0d: got %b/%0d want %b/%0d", k, idct_rapx, cycle_cnt, exp_r, k);
      end
    end
    abort = 1'b1; tick(); abort = 1'b0;
    n_cmp++;
    if ({busy, idct_rapx, cycle_cnt} !== {1'b0, AD, 32'd0}) begin
      n_bad++;
      $display("FAIL rapx_abort: got %b/%b/%0d want 0/%b/0", busy, idct_rapx, cycle_cnt, AD);
    end
  endtask

  task automatic test_abort();
    int acc, guard, rdy;
    bit stop;
    logic v;
    logic [31:0] d;
    acc = 0; guard = 0;
    go = 1'b1; tick(); go = 1'b0;
    while (acc < 37 && guard < 500) begin
      guard++;
      v = $urandom_range(0, 1);
      d = $urandom;
      src_valid = v; dct_reading = 1'b1; src_data = d;
      tick();
      if (v) begin
        acc++;
        din_model = d;
      end
    end
    abort = 1'b1; go = 1'b1; src_valid = 1'b1; src_data = $urandom;
    tick();
    abort = 1'b0; go = 1'b0; src_valid = 1'b0;
    n_cmp++;
    if ({busy, idct_racc, dct_start, frame_done, timeout, src_ready} !== 6'b010000) begin
      n_bad++;
      $display("FAIL abort_flags: got %b want 010000", {busy, idct_racc, dct_start, frame_done, timeout, src_ready});
    end
    n_cmp++;
    if ({dct_din, cycle_cnt} !== {din_model, 32'd0}) begin
      n_bad++;
      $display("FAIL abort_data: din=%h cyc=%0d want %h/0", dct_din, cycle_cnt, din_model);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if ({busy, frame_done} !== 2'b00) begin
        n_bad++;
        $display("FAIL abort_idle k=%0d: got %b want 00", k, {busy, frame_done});
      end
    end
    go = 1'b1; tick(); go = 1'b0;
    rdy = 0; guard = 0; stop = 1'b0;
    while (!stop && guard < 300) begin
      guard++;
      d = $urandom;
      src_valid = 1'b1; dct_reading = 1'b1; src_data = d;
      #1;
      if (src_ready) begin
        rdy++;
        tick();
        din_model = d;
      end else begin
        stop = 1'b1;
      end
    end
    n_cmp++;
    if (rdy != NB * 64) begin
      n_bad++;
      $display("FAIL abort_reload: got %0d accepts want %0d", rdy, NB * 64);
    end
    n_cmp++;
    if (dct_din !== din_model) begin
      n_bad++;
      $display("FAIL reload_din: got %h want %h", dct_din, din_model);
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({dct_start, src_ready, idct_racc, idct_rapx, coef_valid, pix_valid, busy, frame_done, timeout}
        !== {1'b0, 1'b0, 1'b1, AD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL midreset_flags: got %b", {dct_start, src_ready, idct_racc, idct_rapx, coef_valid,
               pix_valid, busy, frame_done, timeout});
    end
    n_cmp++;
    if ({dct_din, coef_data, pix_data, cycle_cnt} !== 100'd0) begin
      n_bad++;
      $display("FAIL midreset_data: din=%h coef=%h pix=%h cyc=%0d want all zero", dct_din, coef_data, pix_data, cycle_cnt);
    end
    din_model = '0; coef_model = '0; pix_model = '0;
    src_valid = 1'b0; dct_reading = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    tick();
    n_cmp++;
    if ({busy, idct_racc} !== 2'b01) begin
      n_bad++;
      $display("FAIL post_reset: got %b want 01", {busy, idct_racc});
    end
  endtask

  initial begin
    test_reset();
    test_load_timeout(1'b0);
    test_load_timeout(1'b1);
    test_coef();
    test_blocks(12, 3, 1, 2);
    test_blocks(12, 3, 2, 1);
    test_blocks(0, 0, 1, 0);
    for (int i = 0; i < 4; i++)
      test_blocks($urandom_range(0, 12), $urandom_range(0, 3), $urandom_range(1, 3), $urandom_range(0, 3));
    test_rapx();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dct_idct_frame_sequencer.md
Name: dct_idct_frame_sequencer

Overview:
Sequences one frame of 8x8 blocks through the dct -> idct pipeline.
- Meters source pixels into the dct while it reports reading.
- Drives idct racc/rapx: rapx follows a programmable cycle-count window for precision scheduling.
- Sign-extends dct coefficients into the idct and captures 64 coefficients and 64 pixels per block.
- Terminates the frame on completion or on a drain timeout.

Parameters:
BitWidth, 31, MSB index of the pipeline data bus (bus is BitWidth+1 bits).
NUM_BLOCKS, 1024, number of 8x8 blocks per frame (1024 x 64 = 65536 samples).
DRAIN_TIMEOUT, 16384, maximum cycles allowed in DRAIN.
APX_LO, 500000, lower bound of the rapx window (exclusive).
APX_HI, 1000000, upper bound of the rapx window (exclusive).
APX_DEFAULT, 1, rapx value outside the window.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
go  in  1  single-cycle frame start; ignored unless IDLE
abort  in  1  return to IDLE, highest priority
src_valid  in  1  source pixel valid
src_data  in  BitWidth+1  source pixel
src_ready  out  1  pixel accepted this cycle when src_valid=1
dct_start  out  1  dct start
dct_din  out  BitWidth+1  registered pixel to dct
dct_reading  in  1  dct accepting input
dct_done  in  1  dct output window
dct_dout  in  BitWidth+1  dct output
idct_din  out  BitWidth+1  {18 copies of dct_dout[31], dct_dout[31:18]}, combinational
idct_racc  out  1  idct reset
idct_rapx  out  1  idct approximate-mode select
idct_done  in  1  idct output window
idct_dout  in  BitWidth+1  idct output
coef_valid  out  1  coefficient sample valid
coef_data  out  14  dct_dout[31:18], registered
pix_valid  out  1  reconstructed pixel valid
pix_data  out  22  idct_dout[31:10], registered
busy  out  1  state != IDLE
frame_done  out  1  one-cycle pulse at frame end
timeout  out  1  sticky; set if DRAIN ended by timeout; cleared on go
cycle_cnt  out  32  cycles since go

Behaviour:
- Reset values:
  - dct_start=0, dct_din=0, src_ready=0.
  - idct_racc=1, idct_rapx=APX_DEFAULT.
  - coef_valid=0, coef_data=0, pix_valid=0, pix_data=0.
  - busy=0, frame_done=0, timeout=0, cycle_cnt=0.
  - state=IDLE, all internal counters 0.
- IDLE:
  - idct_racc=1, dct_start=0.
  - go=1 -> LOAD next cycle; clears in_cnt, blk_cnt, cycle_cnt, timeout.
- LOAD:
  - idct_racc=0, dct_start=1.
  - src_ready = dct_reading (combinational).
  - On src_valid & dct_reading: dct_din <= src_data; in_cnt++.
  - When in_cnt reaches NUM_BLOCKS*64 (the accepting edge) -> DRAIN; src_ready=0 from then on.
- DRAIN:
  - dct_start held 1 until the first cycle dct_reading=0, then 0 for the rest of the frame.
  - drain_cnt increments each cycle.
  - blk_cnt == NUM_BLOCKS -> DONE.
  - Else drain_cnt == DRAIN_TIMEOUT-1 -> DONE with timeout<=1.
- DONE:
  - frame_done=1 for exactly one cycle, then IDLE.
  - idct_racc reasserts on entry to IDLE.
- abort:
  - In any state, IDLE next cycle.
  - All counters cleared, capture counters cleared.
  - No frame_done pulse; timeout unchanged.
  - abort takes precedence over go in the same cycle.
- Coefficient capture (every cycle, any non-IDLE state):
  - dct_done=1 and coef_cnt<64: coef_valid<=1, coef_data<=dct_dout[31:18], coef_cnt++.
  - dct_done=1 and coef_cnt==64: coef_valid<=0, extra samples discarded.
  - dct_done=0: coef_cnt<=0, coef_valid<=0.
- Pixel capture: identical rule on idct_done/idct_dout[31:10] with pix_cnt.
  - The 64th accepted pixel increments blk_cnt.
  - Latency from input to pix_valid is 1 cycle.
- rapx scheduling:
  - cycle_cnt increments every non-IDLE cycle; saturates at 2^32-1.
  - idct_rapx <= 1 when APX_LO < cycle_cnt < APX_HI, else APX_DEFAULT (registered, one cycle behind cycle_cnt).
  - In IDLE, idct_rapx = APX_DEFAULT.
- Simultaneous events:
  - Last input acceptance and a block completing in the same cycle: both counted.
  - blk_cnt reaching NUM_BLOCKS on the timeout cycle: completion wins, timeout=0.
- Reset mid-frame: immediate return to reset values; no partial outputs.

Test Plan:
1. NUM_BLOCKS=2; go; src_valid=1, dct_reading=1 always -> src_ready=1 for exactly 128 cycles, dct_din follows src_data one cycle late, then DRAIN.
2. dct_done high 70 cycles, dct_dout=32'hFFFC_0000 -> exactly 64 coef_valid pulses, coef_data=14'h3FFF; idct_din=32'hFFFF_FFFF.
3. NUM_BLOCKS=2; two idct_done windows of 64 cycles -> blk_cnt=2, one frame_done pulse, timeout=0, busy falls the cycle after frame_done.
4. DRAIN_TIMEOUT=16, no idct_done -> frame_done 16 cycles after DRAIN entry, timeout=1; next go clears timeout.
5. APX_LO=10, APX_HI=20, APX_DEFAULT=0 -> idct_rapx=1 for cycle_cnt 11..19 (one cycle delayed), 0 elsewhere.
6. abort during LOAD at in_cnt=37 together with go -> IDLE next cycle, idct_racc=1, no frame_done; reset_n pulse mid-DRAIN -> all outputs at reset values asynchronously.
